tri_bus_reader: RTL
===================

TRI_BUS_READER -- requirements
Module: tri_bus_reader

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set payload bits per frame.
REQ-002 Parameter OVS, default 4 (even, >=4), SHALL set clock cycles per bit on the shared line.
REQ-003 Port clk  input  1  sole clock; all state on its rising edge.
REQ-004 Port rst_n  input  1  reset, synchronous, active-low.
REQ-005 Port bus_in  input  1  shared tristate line driven by the bus's tristate writers; idles high (pulled to Vdd).
REQ-006 Port rd_ack  input  1  consumer accepts data; effective only while valid=1.
REQ-007 Port data  output  DATA_W  last received payload, LSB first on the wire.
REQ-008 Port valid  output  1  data holds an unconsumed frame.
REQ-009 Port par_err  output  1  parity flag for the frame in data.
REQ-010 Port frm_err  output  1  stop-bit flag for the frame in data.
REQ-011 Port ovr_err  output  1  sticky; a frame completed while valid=1.
REQ-012 Port busy  output  1  high in any state other than IDLE.

Function
REQ-013 Frame format SHALL be: start (0), DATA_W data bits LSB first, even-parity bit, stop (1); each bit OVS cycles.
REQ-014 bus_in SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value (sb) and its previous value.
REQ-015 States SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-016 IDLE: on sb falling edge (prev 1, now 0) -> START, bit-cycle counter cleared.
REQ-017 START: at counter = OVS/2-1, sample sb; 0 -> DATA with counter cleared; 1 -> IDLE (glitch rejected, no flags).
REQ-018 DATA: sample sb every OVS cycles (mid-bit); shift into shift register at bit index; after DATA_W samples -> PARITY.
REQ-019 PARITY: sample after OVS cycles; par_err candidate = XOR of data bits XOR parity bit.
REQ-020 STOP: sample after OVS cycles; frm_err candidate = (sb == 0); always -> IDLE.
REQ-021 On STOP sample, the cycle after SHALL show data, par_err, frm_err updated and valid=1 (1-cycle latency from stop sample).
REQ-022 valid SHALL stay high until the cycle after rd_ack=1 is sampled with valid=1; data/flags hold meanwhile.
REQ-023 Frame completing while valid=1 and rd_ack=0: data and flags SHALL be overwritten, valid stays 1, ovr_err set.
REQ-024 Frame completing in the same cycle rd_ack=1 is sampled: new frame loaded, valid stays 1, ovr_err not set.
REQ-025 ovr_err SHALL clear only on reset.
REQ-026 After STOP with frm_err, IDLE SHALL require sb high before a new falling edge is accepted (edge rule covers this).
REQ-027 Counter width SHALL be clog2(OVS); bit index width clog2(DATA_W+1); no wrap beyond terminal counts.

Reset
REQ-028 With rst_n=0 at a clk edge: state=IDLE, counters 0, synchronizer flops 1, data=0, valid=0, par_err=0, frm_err=0, ovr_err=0, busy=0.
REQ-029 Reset mid-frame SHALL abandon the frame without asserting valid or any flag.

Structure
REQ-030 Package tri_bus_pkg SHALL hold the state enum, default DATA_W/OVS constants, and the frame-length constant.
REQ-031 The 2-flop synchronizer SHALL be sub-module tri_bus_sync (reset value 1, same clk/rst_n).
REQ-032 Total RTL SHALL target 150-300 lines; single FSM process plus datapath registers.

Verification (DATA_W=8, OVS=4)
REQ-033 Frame 0xA5, parity 0, stop 1 -> data=0xA5, valid=1, par_err=0, frm_err=0; rd_ack -> valid=0 next cycle.
REQ-034 Frame 0x3C with parity bit 1 -> data=0x3C, par_err=1, frm_err=0.
REQ-035 Frame 0x01, parity 1, stop 0 -> data=0x01, frm_err=1; next frame 0x02 after line high 4 cycles -> received cleanly.
REQ-036 bus_in low 2 cycles then high -> state returns IDLE, valid stays 0, busy drops within OVS/2+2 cycles.
REQ-037 Frames 0x11 then 0x22 with no rd_ack -> data=0x22, valid=1, ovr_err=1.
REQ-038 rst_n=0 during bit 4 of a frame -> all outputs 0 next cycle; subsequent frame 0x5A received correctly.

Source files
------------

// File: rtl/tri_bus_pkg.sv
// Shared types and defaults for the tristate-bus frame reader.
package tri_bus_pkg;

    localparam int DEF_DATA_W     = 8;
    localparam int DEF_OVS        = 4;
    // start + payload + parity + stop
    localparam int DEF_FRAME_BITS = DEF_DATA_W + 3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_e;

    // Number of line bits in a frame for a given payload width.
    function automatic int frame_bits(input int data_w);
        return data_w + 3;
    endfunction

endpackage

// File: rtl/tri_bus_sync.sv
// Two-flop synchronizer for the shared line; resets to the idle (high) level.
module tri_bus_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic s1_d, s1_q;
    logic s2_d, s2_q;

    // Next-state values for the synchronizer chain.
    always_comb begin
        s1_d = d;
        s2_d = s1_q;
    end

    // Synchronizer flops, synchronous active-low reset to the idle level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/tri_bus_reader.sv
// Receiver for start/data/even-parity/stop frames on an oversampled shared line.
module tri_bus_reader
    import tri_bus_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int OVS    = DEF_OVS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bus_in,
    input  logic              rd_ack,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    output logic              par_err,
    output logic              frm_err,
    output logic              ovr_err,
    output logic              busy
);

    localparam int CNT_W = (OVS > 1) ? $clog2(OVS) : 1;
    localparam int IDX_W = $clog2(DATA_W + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVS - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVS / 2 - 1);
    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    // XOR reduction of the payload; combined with the parity bit it flags odd totals.
    function automatic logic payload_parity(input logic [DATA_W-1:0] v);
        return ^v;
    endfunction

    logic sb_s;

    state_e              state_d, state_q;
    logic [CNT_W-1:0]    cnt_d, cnt_q;
    logic [IDX_W-1:0]    idx_d, idx_q;
    logic [DATA_W-1:0]   shift_d, shift_q;
    logic                par_cand_d, par_cand_q;
    logic                sb_prev_d, sb_prev_q;
    logic [DATA_W-1:0]   data_d, data_q;
    logic                valid_d, valid_q;
    logic                par_err_d, par_err_q;
    logic                frm_err_d, frm_err_q;
    logic                ovr_err_d, ovr_err_q;
    logic                busy_d, busy_q;
    logic                load_s;
    logic                frm_cand_s;

    tri_bus_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus_in),
        .q     (sb_s)
    );

    // Frame FSM, bit timing, payload assembly and the consumer handshake.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        par_cand_d = par_cand_q;
        sb_prev_d  = sb_s;
        data_d     = data_q;
        valid_d    = valid_q;
        par_err_d  = par_err_q;
        frm_err_d  = frm_err_q;
        ovr_err_d  = ovr_err_q;
        load_s     = 1'b0;
        frm_cand_s = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Only a genuine high-to-low transition starts a frame, so a
                // line held low after a bad stop bit is ignored until it rises.
                if (sb_prev_q && !sb_s) begin
                    state_d = ST_START;
                    cnt_d   = CNT_ZERO;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d = CNT_ZERO;
                    idx_d = IDX_ZERO;
                    if (!sb_s) begin
                        state_d = ST_DATA;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    // LSB arrives first: shifting in from the top leaves it at bit 0.
                    shift_d = {sb_s, shift_q[DATA_W-1:1]};
                    cnt_d   = CNT_ZERO;
                    idx_d   = idx_q + IDX_ONE;
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_PARITY;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_PARITY: begin
                if (cnt_q == CNT_LAST) begin
                    par_cand_d = payload_parity(shift_q) ^ sb_s;
                    cnt_d      = CNT_ZERO;
                    state_d    = ST_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    load_s     = 1'b1;
                    frm_cand_s = ~sb_s;
                    cnt_d      = CNT_ZERO;
                    state_d    = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
                idx_d   = IDX_ZERO;
            end
        endcase

        // A completing frame always wins; it counts as an overrun only if the
        // previous frame is still pending and not being acknowledged this cycle.
        if (load_s) begin
            data_d    = shift_q;
            par_err_d = par_cand_q;
            frm_err_d = frm_cand_s;
            valid_d   = 1'b1;
            if (valid_q && !rd_ack) begin
                ovr_err_d = 1'b1;
            end else begin
                ovr_err_d = ovr_err_q;
            end
        end else if (valid_q && rd_ack) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= CNT_ZERO;
            idx_q      <= IDX_ZERO;
            shift_q    <= {DATA_W{1'b0}};
            par_cand_q <= 1'b0;
            sb_prev_q  <= 1'b1;
            data_q     <= {DATA_W{1'b0}};
            valid_q    <= 1'b0;
            par_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
            ovr_err_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            par_cand_q <= par_cand_d;
            sb_prev_q  <= sb_prev_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            par_err_q  <= par_err_d;
            frm_err_q  <= frm_err_d;
            ovr_err_q  <= ovr_err_d;
            busy_q     <= busy_d;
        end
    end

    assign data    = data_q;
    assign valid   = valid_q;
    assign par_err = par_err_q;
    assign frm_err = frm_err_q;
    assign ovr_err = ovr_err_q;
    assign busy    = busy_q;

endmodule
